// File: rtl/avalon_msg_truncator_if.sv
// Avalon-ST beat interface: valid/rdy handshake with sop/eop framing and
// a byte-count "empty" field on the eop beat (low bytes are the invalid ones).
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
  localparam int unsigned EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic                               valid;
  logic                               rdy;
  logic                               sop;
  logic                               eop;
  logic [DATA_WIDTH_IN_BYTES*8-1:0]   data;
  logic [EMPTY_W-1:0]                 empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_msg_truncator.sv
// Limits every Avalon-ST message to MAX_MSG_BYTES: cuts over-long messages,
// discards their tail, and reports the forwarded length per message.
module avalon_msg_truncator #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned MAX_MSG_BYTES       = 64,
  localparam int unsigned LEN_W              = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  avalon_st_if.slave       msg_in,
  avalon_st_if.master      msg_out,
  output logic [LEN_W-1:0] msg_len,
  output logic             msg_len_valid,
  output logic             msg_truncated
);
  localparam int unsigned W       = DATA_WIDTH_IN_BYTES;
  localparam int unsigned EMPTY_W = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW      = $clog2(MAX_MSG_BYTES + W + 1);

  typedef enum logic [1:0] {BETWEEN_MSG, IN_MSG, DROP} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   msg_len_q, msg_len_d;
  logic               len_valid_q, len_valid_d;
  logic               trunc_q, trunc_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [W*8-1:0]     out_data_q, out_data_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;

  logic               in_rdy, accept, cut, load;
  logic [CW-1:0]      base, beat_bytes, sum, remain;
  logic [EMPTY_W-1:0] new_empty;

  assign in_rdy = (state_q == DROP) || !out_valid_q || msg_out.rdy;
  assign accept = msg_in.valid && in_rdy;

  always_comb begin
    base       = (state_q == IN_MSG) ? CW'(cnt_q) : '0;
    beat_bytes = msg_in.eop ? (CW'(W) - CW'(msg_in.empty)) : CW'(W);
    sum        = base + beat_bytes;
    remain     = CW'(MAX_MSG_BYTES) - base;
    // A non-eop beat reaching the limit exactly still has more bytes behind it.
    cut        = msg_in.eop ? (sum > CW'(MAX_MSG_BYTES)) : (sum >= CW'(MAX_MSG_BYTES));
    if (cut)             new_empty = EMPTY_W'(CW'(W) - remain);
    else if (msg_in.eop) new_empty = msg_in.empty;
    else                 new_empty = '0;
    load = accept && ((state_q == IN_MSG) || (state_q == BETWEEN_MSG && msg_in.sop));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msg_len_d   = msg_len_q;
    len_valid_d = 1'b0;
    trunc_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_empty_d = out_empty_q;

    if (out_valid_q && msg_out.rdy) out_valid_d = 1'b0;

    if (accept && state_q == DROP && msg_in.eop) state_d = BETWEEN_MSG;

    if (load) begin
      out_valid_d = 1'b1;
      out_sop_d   = (state_q == BETWEEN_MSG);
      out_eop_d   = msg_in.eop || cut;
      out_empty_d = new_empty;
      for (int unsigned i = 0; i < W; i++)
        out_data_d[8*i +: 8] = (i < 32'(new_empty)) ? 8'h00 : msg_in.data[8*i +: 8];
      if (cut) begin
        msg_len_d   = LEN_W'(MAX_MSG_BYTES);
        len_valid_d = 1'b1;
        trunc_d     = 1'b1;
        cnt_d       = '0;
        state_d     = msg_in.eop ? BETWEEN_MSG : DROP;
      end else if (msg_in.eop) begin
        msg_len_d   = LEN_W'(sum);
        len_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = BETWEEN_MSG;
      end else begin
        cnt_d       = LEN_W'(sum);
        state_d     = IN_MSG;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BETWEEN_MSG;
      cnt_q       <= '0;
      msg_len_q   <= '0;
      len_valid_q <= 1'b0;
      trunc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_empty_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      msg_len_q   <= msg_len_d;
      len_valid_q <= len_valid_d;
      trunc_q     <= trunc_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      out_empty_q <= out_empty_d;
    end
  end

  assign msg_in.rdy      = in_rdy;
  assign msg_out.valid   = out_valid_q;
  assign msg_out.sop     = out_sop_q;
  assign msg_out.eop     = out_eop_q;
  assign msg_out.data    = out_data_q;
  assign msg_out.empty   = out_empty_q;
  assign msg_len         = msg_len_q;
  assign msg_len_valid   = len_valid_q;
  assign msg_truncated   = trunc_q;
endmodule

// File: tb/tb_avalon_msg_truncator.sv
// Bench for avalon_msg_truncator: two instances (MAX 64 and MAX 40) share one
// stimulus driver, selected by sel; a message-level model predicts all outputs.
module tb_avalon_msg_truncator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sel;
  logic         in_valid, in_sop, in_eop, out_rdy;
  logic [127:0] in_data;
  logic [3:0]   in_empty;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in_a ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out_a ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in_b ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out_b ();

  logic [6:0] len_a;
  logic [5:0] len_b;
  logic       lv_a, lv_b, tr_a, tr_b;

  assign in_a.valid = in_valid && !sel;
  assign in_a.sop   = in_sop;
  assign in_a.eop   = in_eop;
  assign in_a.data  = in_data;
  assign in_a.empty = in_empty;
  assign out_a.rdy  = out_rdy;
  assign in_b.valid = in_valid && sel;
  assign in_b.sop   = in_sop;
  assign in_b.eop   = in_eop;
  assign in_b.data  = in_data;
  assign in_b.empty = in_empty;
  assign out_b.rdy  = out_rdy;

  avalon_msg_truncator #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_BYTES(64)) dut_a (
    .clk(clk), .rst(rst), .msg_in(in_a), .msg_out(out_a),
    .msg_len(len_a), .msg_len_valid(lv_a), .msg_truncated(tr_a));

  avalon_msg_truncator #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_BYTES(40)) dut_b (
    .clk(clk), .rst(rst), .msg_in(in_b), .msg_out(out_b),
    .msg_len(len_b), .msg_len_valid(lv_b), .msg_truncated(tr_b));

  logic         m_in_rdy, m_ov, m_osop, m_oeop, m_lv, m_tr;
  logic [127:0] m_odata;
  logic [3:0]   m_oempty;
  logic [6:0]   m_len;

  assign m_in_rdy = sel ? in_b.rdy   : in_a.rdy;
  assign m_ov     = sel ? out_b.valid : out_a.valid;
  assign m_osop   = sel ? out_b.sop   : out_a.sop;
  assign m_oeop   = sel ? out_b.eop   : out_a.eop;
  assign m_odata  = sel ? out_b.data  : out_a.data;
  assign m_oempty = sel ? out_b.empty : out_a.empty;
  assign m_len    = sel ? {1'b0, len_b} : len_a;
  assign m_lv     = sel ? lv_b : lv_a;
  assign m_tr     = sel ? tr_b : tr_a;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
    logic [127:0] data;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  bit    mdl_active, mdl_drop;
  int unsigned mdl_bytes;
  bit    len_due, exp_tr;
  int unsigned exp_len;
  bit    prev_stall;
  beat_t prev_beat;
  int unsigned last_len;
  bit    last_tr;
  logic [3:0]   last_empty;
  logic [127:0] last_data;
  int    out_beats = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] gen_data(input int tag);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'((tag << 4) + k + 8'h11);
    return d;
  endfunction

  // Message-level prediction: how many bytes of this message survive the limit.
  task automatic model_accept(input int unsigned maxb);
    int unsigned avail, total, keep;
    bit cut;
    beat_t b;
    if (mdl_drop) begin
      if (in_eop) mdl_drop = 1'b0;
      return;
    end
    if (!mdl_active && !in_sop) return;
    if (!mdl_active) mdl_bytes = 0;
    avail = in_eop ? 16 - int'(in_empty) : 16;
    total = mdl_bytes + avail;
    cut   = (total > maxb) || (!in_eop && total >= maxb);
    keep  = cut ? maxb - mdl_bytes : avail;
    b.sop   = !mdl_active;
    b.eop   = in_eop || cut;
    b.empty = cut ? 4'(16 - keep) : (in_eop ? in_empty : 4'd0);
    b.data  = in_data;
    for (int k = 0; k < 16; k++) if (k < int'(b.empty)) b.data[8*k +: 8] = 8'h00;
    exp_q.push_back(b);
    if (b.eop) begin
      len_due    = 1'b1;
      exp_len    = mdl_bytes + keep;
      exp_tr     = cut;
      mdl_active = 1'b0;
      mdl_drop   = cut && !in_eop;
    end else begin
      mdl_bytes  = mdl_bytes + 16;
      mdl_active = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    beat_t got, e;
    if (rst) begin
      exp_q.delete();
      mdl_active = 1'b0;
      mdl_drop   = 1'b0;
      mdl_bytes  = 0;
      len_due    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      got = '{m_osop, m_oeop, m_oempty, m_odata};
      if (prev_stall) begin
        chk("stall_valid", m_ov, 1'b1);
        chk("stall_hold", got, prev_beat);
      end
      chk("in_rdy", m_in_rdy, mdl_drop || !m_ov || out_rdy);
      chk("len_valid", m_lv, len_due);
      if (len_due) begin
        chk("msg_len", m_len, exp_len);
        chk("msg_truncated", m_tr, exp_tr);
      end else begin
        chk("trunc_idle", m_tr, 1'b0);
      end
      if (m_lv) begin
        last_len = m_len;
        last_tr  = m_tr;
      end
      if (m_ov && out_rdy) begin
        out_beats++;
        last_empty = m_oempty;
        last_data  = m_odata;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat got=%0h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", got, e);
        end
      end
      prev_stall = m_ov && !out_rdy;
      prev_beat  = got;
      len_due    = 1'b0;
      if (in_valid && m_in_rdy) model_accept(sel ? 40 : 64);
    end
  end

  task automatic send(input bit s, input bit e, input logic [3:0] emp, input int tag);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_empty = emp;
    in_data  = gen_data(tag);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = m_in_rdy;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=not_accepted exp=accepted tag=%0d", tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input int nbeats, input int last_empty, input int tag0);
    for (int b = 0; b < nbeats; b++)
      send(b == 0, b == nbeats - 1, (b == nbeats - 1) ? 4'(last_empty) : 4'd0, tag0 + b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ob0;
    rst = 1'b1; sel = 1'b0; out_rdy = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; in_data = '0;
    @(negedge clk);
    chk("rst_valid", m_ov, 1'b0);
    chk("rst_sop_eop", {m_osop, m_oeop}, 2'b00);
    chk("rst_data", m_odata, 128'd0);
    chk("rst_empty", m_oempty, 4'd0);
    chk("rst_len", {m_len, m_lv, m_tr}, 9'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // 64-byte message fits exactly
    send_msg(4, 0, 1); idle(4);
    chk("t1_len", last_len, 64); chk("t1_tr", last_tr, 1'b0);

    // 96-byte message cut after 4 beats, tail dropped
    ob0 = out_beats;
    send_msg(6, 0, 10); idle(4);
    chk("t2_len", last_len, 64); chk("t2_tr", last_tr, 1'b1);
    chk("t2_beats", out_beats - ob0, 4);

    // backpressure toggling every cycle, 43-byte message
    ob0 = out_beats;
    fork
      send_msg(3, 5, 20);
      begin
        repeat (14) begin @(posedge clk); #1 out_rdy = !out_rdy; end
        out_rdy = 1'b1;
      end
    join
    idle(4);
    chk("t3_len", last_len, 43); chk("t3_tr", last_tr, 1'b0);
    chk("t3_beats", out_beats - ob0, 3);

    // reset in the middle of a message
    send(1'b1, 1'b0, 4'd0, 30);
    send(1'b0, 1'b0, 4'd0, 31);
    out_rdy = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("t4_async_valid", m_ov, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; out_rdy = 1'b1;
    idle(1);
    send_msg(3, 3, 40); idle(4);
    chk("t4_len", last_len, 45); chk("t4_tr", last_tr, 1'b0);

    // stray non-sop beat, then 1-byte message
    ob0 = out_beats;
    send(1'b0, 1'b0, 4'd0, 50);
    send(1'b1, 1'b1, 4'd15, 51);
    idle(4);
    chk("t5_len", last_len, 1); chk("t5_beats", out_beats - ob0, 1);

    sel = 1'b1;
    idle(2);
    // MAX 40: 44-byte message cut on its eop beat
    send_msg(3, 4, 60); idle(4);
    chk("t6_len", last_len, 40); chk("t6_tr", last_tr, 1'b1);
    chk("t6_empty", last_empty, 4'd8);
    chk("t6_zero", last_data[63:0], 64'd0);
    send_msg(1, 0, 70); idle(4);
    chk("t7_len", last_len, 16); chk("t7_tr", last_tr, 1'b0);
    // exact fit of 40 bytes
    send_msg(3, 8, 80); idle(4);
    chk("t8_len", last_len, 40); chk("t8_tr", last_tr, 1'b0);
    // non-eop beat crossing the limit, drop the tail
    ob0 = out_beats;
    send_msg(4, 2, 90); idle(4);
    chk("t9_len", last_len, 40); chk("t9_tr", last_tr, 1'b1);
    chk("t9_beats", out_beats - ob0, 3);
    chk("t9_empty", last_empty, 4'd8);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
